// File: rtl/inst_fetch.sv
// Instruction fetch stage: walks fetch_pc through a combinational instruction ROM
// and buffers {pc, inst} pairs in a 2-entry FIFO feeding decode.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [9:0]  rom_addr,
    input  logic [31:0] rom_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    fetch_state_t state;
    fetch_state_t state_next;

    logic [31:0] fetch_pc;
    logic [31:0] head_pc;
    logic [31:0] head_inst;
    logic [31:0] tail_pc;
    logic [31:0] tail_inst;
    logic [1:0]  count;
    logic        push;
    logic        pop;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Redirects never touch the FSM; only halt steers RUN/HALT.
    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (halt) state_next = HALT;
            HALT:    if (!halt) state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        pop  = (count != 2'd0) && out_ready;
        push = (state == RUN) && !halt && !redirect_valid &&
               ((count != 2'd2) || pop);
    end

    // A redirect wins over push and pop: the FIFO is flushed even if its head was taken.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc  <= RESET_PC;
            count     <= 2'd0;
            head_pc   <= 32'd0;
            head_inst <= 32'd0;
            tail_pc   <= 32'd0;
            tail_inst <= 32'd0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            count    <= 2'd0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_pc   <= fetch_pc;
                        head_inst <= rom_inst;
                    end else begin
                        tail_pc   <= fetch_pc;
                        tail_inst <= rom_inst;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_pc   <= tail_pc;
                    head_inst <= tail_inst;
                    count     <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_pc   <= fetch_pc;
                        head_inst <= rom_inst;
                    end else begin
                        head_pc   <= tail_pc;
                        head_inst <= tail_inst;
                        tail_pc   <= fetch_pc;
                        tail_inst <= rom_inst;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        rom_addr  = fetch_pc[11:2];
        out_valid = (count != 2'd0);
        out_pc    = out_valid ? head_pc : 32'd0;
        out_inst  = out_valid ? head_inst : 32'd0;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, which is the byte address of the first fetch after reset.
REQ-002 SHALL have port clk, input, 1 bit; it is the single clock, and all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit; it is an asynchronous, active-low reset.
REQ-004 SHALL have port rom_addr, output, 10 bits; it is the word address to the instruction ROM and equals fetch_pc[11:2].
REQ-005 SHALL have port rom_inst, input, 32 bits; it is the ROM data for rom_addr, returned combinationally in the same cycle.
REQ-006 SHALL have port redirect_valid, input, 1 bit; it is a branch/jump redirect request.
REQ-007 SHALL have port redirect_pc, input, 32 bits; it is the redirect target byte address.
REQ-008 SHALL have port halt, input, 1 bit; while high it suspends fetching.
REQ-009 SHALL have port out_valid, output, 1 bit; when high the buffer head holds an instruction.
REQ-010 SHALL have port out_ready, input, 1 bit; when high the decode stage accepts the head.
REQ-011 SHALL have port out_inst, output, 32 bits; it is the instruction word at the head.
REQ-012 SHALL have port out_pc, output, 32 bits; it is the byte address of out_inst.

Function
REQ-013 SHALL hold a 32-bit fetch_pc register and a 2-entry FIFO, with each entry being {pc[31:0], inst[31:0]}, plus a 2-bit count.
REQ-014 SHALL implement an FSM with states BOOT, RUN and HALT.
- Transitions are BOOT->RUN unconditionally after one cycle.
- RUN->HALT when halt=1.
- HALT->RUN when halt=0.
REQ-015 SHALL push {fetch_pc, rom_inst} and advance fetch_pc by 4 in a cycle only when all of the following hold:
- state is RUN,
- halt=0,
- redirect_valid=0,
- count<2, or count==2 with a pop occurring in the same cycle.
REQ-016 SHALL pop the head on every cycle where out_valid=1 and out_ready=1.
REQ-017 SHALL update count as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop; count SHALL never exceed 2 or go below 0.
REQ-018 SHALL drive out_valid as (count!=0), combinationally from registered state.
- out_inst and out_pc come from the head entry.
- When count==0, out_inst and out_pc hold 0.
REQ-019 SHALL, when redirect_valid=1, do all of the following on the next edge:
- set fetch_pc to {redirect_pc[31:2], 2'b00}, so low address bits are forced to zero,
- flush the FIFO (count=0),
- suppress the push for that cycle.
REQ-020 SHALL give redirect priority over push and pop in the same cycle; a head accepted in the redirect cycle counts as consumed but is discarded with the flush.
REQ-021 SHALL apply a redirect in any state; the FSM state SHALL be unchanged by a redirect, so a redirect received in HALT keeps the block in HALT.
REQ-022 SHALL make a redirect target visible on out_pc no earlier than 2 edges after the redirect edge: one edge for the fetch_pc update, one for the push.
REQ-023 SHALL wrap fetch_pc modulo 2^32 (32'hFFFF_FFFC + 4 = 0); rom_addr SHALL wrap modulo 1024 words.
REQ-024 SHALL keep out_valid, out_inst and out_pc stable while out_valid=1 and out_ready=0, unless a redirect occurs.
REQ-025 SHALL not drop, duplicate or reorder instructions between redirects; out_pc SHALL increase by exactly 4 between consecutive pops.

Reset
REQ-026 SHALL, while resetn=0, immediately set:
- state=BOOT,
- fetch_pc=RESET_PC,
- count=0,
- out_valid=0,
- out_inst=0,
- out_pc=0,
- rom_addr=RESET_PC[11:2].
REQ-027 SHALL make the first push occur on the 2nd rising edge after resetn deasserts, so out_valid=1 with out_pc=RESET_PC after that edge.
REQ-028 SHALL, on assertion of resetn mid-operation, discard buffered entries immediately and apply no pending redirect or pop.

Verification
REQ-029 SHALL cover reset and streaming.
- Stimulus: ROM model loaded with word0=32'h24010001, word1=32'h00011100, word2=32'h00411821; out_ready=1.
- Required response: pops occur in the order (pc 0x0, 24010001), (0x4, 00011100), (0x8, 00411821), one per cycle from the 2nd edge onward.
REQ-030 SHALL cover backpressure.
- Stimulus: out_ready=0 for 5 cycles.
- Required response: count saturates at 2; the head holds pc=0x0; fetch_pc=0x8; rom_addr=2.
- On releasing out_ready, pcs 0x0, 0x4, 0x8 emerge on consecutive cycles with no gap or duplicate.
REQ-031 SHALL cover redirect with a full FIFO and simultaneous pop.
- Stimulus: redirect_pc=32'h0000_0067 asserted while count=2 and out_ready=1.
- Required response: out_valid=0 after that edge, and the next output is out_pc=0x64.
REQ-032 SHALL cover halt.
- Stimulus: halt=1 for 3 cycles with out_ready=1.
- Required response: the FIFO drains, then out_valid=0 and fetch_pc is frozen.
- On deasserting halt, fetching resumes at the frozen fetch_pc.
REQ-033 SHALL cover wrap-around.
- Stimulus: redirect to 32'hFFFF_FFFC.
- Required response: rom_addr=10'h3FF, then the next pc is 0x0 with rom_addr=0.
REQ-034 SHALL cover asynchronous reset mid-stream.
- Stimulus: resetn pulled low between clock edges while count=2.
- Required response: out_valid=0 immediately, before the next edge; the restart sequence matches REQ-027.
